// File: rtl/eth_phy_10g_prbs31_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_prbs31_ctrl_pkg
// Shared definitions for the PRBS31 link self-test controller:
//   - FSM state encoding (3-bit constants)
//   - status vector bit positions
//   - saturating add helper, also used by other PHY statistics blocks
// ---------------------------------------------------------------------------
package eth_phy_10g_prbs31_ctrl_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Status vector bit positions
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_PASS      = 2;
    localparam int STAT_TIMEOUT   = 3;
    localparam int STAT_LOCK_LOST = 4;
    localparam int STAT_W         = 5;

    // Widest accumulator the saturating adder supports
    localparam int SAT_MAX_W = 64;

    // True in the states where the test is running and the PRBS enables are on
    function automatic logic is_busy_state(input logic [2:0] s);
        return (s == ST_WAIT_LOCK) || (s == ST_SETTLE) || (s == ST_MEASURE);
    endfunction

    // a + b clamped to 2^width - 1; the sum is formed one bit wider than the
    // operands so the carry out of a full-width add is never lost.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          width
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
        if (sum > lim) begin
            return lim[SAT_MAX_W-1:0];
        end
        return sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/eth_prbs_err_accum.sv
// ---------------------------------------------------------------------------
// eth_prbs_err_accum
// Saturating error accumulator with a measurement-window counter.
//   rx_clk, rx_rst : clock, asynchronous active-high reset
//   clear          : zero accumulator and window counter
//   en             : accumulate err_in this cycle and advance the window
//   err_in         : per-cycle error count
//   window         : window length in cycles (must be >= 1)
//   acc            : registered accumulator value
//   acc_next       : accumulator value including this cycle's err_in
//   win_done       : this enabled cycle is the last one of the window
// ---------------------------------------------------------------------------
module eth_prbs_err_accum #(
    parameter int ERR_WIDTH = 7,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic [ERR_WIDTH-1:0] err_in,
    input  logic [ACC_WIDTH-1:0] window,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] acc_next,
    output logic                 win_done
);
    import eth_phy_10g_prbs31_ctrl_pkg::*;

    localparam logic [ACC_WIDTH-1:0] ONE = ACC_WIDTH'(1);

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] win_cnt_reg;

    always_comb begin
        acc_next = ACC_WIDTH'(sat_add(SAT_MAX_W'(acc_reg), SAT_MAX_W'(err_in), ACC_WIDTH));
        win_done = en && (win_cnt_reg == (window - ONE));
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            acc_reg     <= '0;
            win_cnt_reg <= '0;
        end else if (clear) begin
            acc_reg     <= '0;
            win_cnt_reg <= '0;
        end else if (en) begin
            acc_reg     <= acc_next;
            win_cnt_reg <= win_cnt_reg + ONE;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/eth_phy_10g_prbs31_ctrl.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_prbs31_ctrl
// Sequences a PRBS31 self-test on eth_phy_10g: enables the PRBS generator and
// checker, waits for block lock, discards a settling interval, then sums the
// per-cycle PHY error count over a programmable window and reports the result.
//   rx_clk, rx_rst          : PHY rx clock, asynchronous active-high reset
//   start, abort            : one-cycle control pulses (abort wins)
//   cfg_test_cycles         : window length, latched on start (0 -> 1)
//   cfg_err_threshold       : max errors for pass, latched on start
//   rx_block_lock           : PHY block lock
//   rx_error_count          : PHY per-cycle PRBS error count
//   cfg_tx/rx_prbs31_enable : PRBS enables to the PHY
//   busy, done              : test running / one-cycle completion pulse
//   pass, timeout, lock_lost: results, held in DONE until next start
//   err_total               : saturating accumulated error count
// All outputs are registered and change in the same cycle as the FSM state.
// ---------------------------------------------------------------------------
module eth_phy_10g_prbs31_ctrl #(
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int ERR_WIDTH     = 7,
    parameter int ACC_WIDTH     = 32
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ACC_WIDTH-1:0] cfg_test_cycles,
    input  logic [ACC_WIDTH-1:0] cfg_err_threshold,
    input  logic                 rx_block_lock,
    input  logic [ERR_WIDTH-1:0] rx_error_count,
    output logic                 cfg_tx_prbs31_enable,
    output logic                 cfg_rx_prbs31_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic                 lock_lost,
    output logic [ACC_WIDTH-1:0] err_total
);
    import eth_phy_10g_prbs31_ctrl_pkg::*;

    // One timer serves both WAIT_LOCK and SETTLE
    localparam int TMR_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMR_LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

    logic [2:0]           state_reg,  state_next;
    logic [TMR_W-1:0]     timer_reg,  timer_next;
    logic [ACC_WIDTH-1:0] window_reg, window_next;
    logic [ACC_WIDTH-1:0] thresh_reg, thresh_next;
    logic [STAT_W-1:0]    status_reg, status_next;

    logic                 pass_next, timeout_next, lock_lost_next;
    logic                 acc_clear, acc_en, win_done;
    logic [ACC_WIDTH-1:0] acc, acc_next;

    eth_prbs_err_accum #(
        .ERR_WIDTH (ERR_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_accum (
        .rx_clk   (rx_clk),
        .rx_rst   (rx_rst),
        .clear    (acc_clear),
        .en       (acc_en),
        .err_in   (rx_error_count),
        .window   (window_reg),
        .acc      (acc),
        .acc_next (acc_next),
        .win_done (win_done)
    );

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        window_next    = window_reg;
        thresh_next    = thresh_reg;
        pass_next      = status_reg[STAT_PASS];
        timeout_next   = status_reg[STAT_TIMEOUT];
        lock_lost_next = status_reg[STAT_LOCK_LOST];
        acc_clear      = 1'b0;
        acc_en         = 1'b0;

        if (is_busy_state(state_reg) && abort) begin
            // Cancelled test leaves no results behind
            state_next     = ST_IDLE;
            pass_next      = 1'b0;
            timeout_next   = 1'b0;
            lock_lost_next = 1'b0;
            acc_clear      = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // Abort is ignored here, but still suppresses a same-cycle start
                    if (start && !abort) begin
                        state_next     = ST_WAIT_LOCK;
                        timer_next     = '0;
                        window_next    = (cfg_test_cycles == '0) ? ACC_WIDTH'(1) : cfg_test_cycles;
                        thresh_next    = cfg_err_threshold;
                        pass_next      = 1'b0;
                        timeout_next   = 1'b0;
                        lock_lost_next = 1'b0;
                        acc_clear      = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (rx_block_lock) begin
                        state_next = ST_SETTLE;
                        timer_next = '0;
                    end else if (timer_reg == TMR_LOCK_LAST) begin
                        state_next   = ST_DONE;
                        timeout_next = 1'b1;
                        pass_next    = 1'b0;
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (!rx_block_lock) begin
                        state_next     = ST_DONE;
                        lock_lost_next = 1'b1;
                        pass_next      = 1'b0;
                    end else if (timer_reg == TMR_SETTLE_LAST) begin
                        state_next = ST_MEASURE;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end
                ST_MEASURE: begin
                    // The current cycle's errors count even if lock drops now
                    acc_en = 1'b1;
                    if (!rx_block_lock) begin
                        state_next     = ST_DONE;
                        lock_lost_next = 1'b1;
                        pass_next      = 1'b0;
                    end else if (win_done) begin
                        state_next = ST_DONE;
                        pass_next  = (acc_next <= thresh_reg);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        status_next                 = '0;
        status_next[STAT_BUSY]      = is_busy_state(state_next);
        status_next[STAT_DONE]      = (state_next == ST_DONE) && (state_reg != ST_DONE);
        status_next[STAT_PASS]      = pass_next;
        status_next[STAT_TIMEOUT]   = timeout_next;
        status_next[STAT_LOCK_LOST] = lock_lost_next;
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_reg  <= ST_IDLE;
            timer_reg  <= '0;
            window_reg <= '0;
            thresh_reg <= '0;
            status_reg <= '0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            window_reg <= window_next;
            thresh_reg <= thresh_next;
            status_reg <= status_next;
        end
    end

    // PRBS enables follow busy, so reset drops them without waiting for a clock
    assign cfg_tx_prbs31_enable = status_reg[STAT_BUSY];
    assign cfg_rx_prbs31_enable = status_reg[STAT_BUSY];
    assign busy                 = status_reg[STAT_BUSY];
    assign done                 = status_reg[STAT_DONE];
    assign pass                 = status_reg[STAT_PASS];
    assign timeout              = status_reg[STAT_TIMEOUT];
    assign lock_lost            = status_reg[STAT_LOCK_LOST];
    assign err_total            = acc;

endmodule

// File: tb/tb_eth_phy_10g_prbs31_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eth_phy_10g_prbs31_ctrl
// Table-driven directed test of the PRBS31 test controller with a stubbed PHY
// (lock and error count driven directly), plus hand-written sequences for
// abort, start+abort, async reset and an 8-bit accumulator saturation case.
// Edge numbering: edge 0 samples start; with lock held from the start the
// FSM spends 1 cycle in WAIT_LOCK, 16 in SETTLE, then MEASURE from edge 18.
// ---------------------------------------------------------------------------
module tb_eth_phy_10g_prbs31_ctrl;

    logic        rx_clk = 1'b0;
    logic        rx_rst = 1'b1;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic        lock   = 1'b0;
    logic [31:0] cfg_cycles = '0;
    logic [31:0] cfg_thr    = '0;
    logic [6:0]  err        = '0;

    logic        tx_en, rx_en, busy, done, pass, timeout, lock_lost;
    logic [31:0] err_total;

    logic [7:0]  cfg8_cycles = 8'd10;
    logic [7:0]  cfg8_thr    = 8'd254;
    logic [6:0]  err8        = 7'd66;
    logic        tx_en8, rx_en8, busy8, done8, pass8, timeout8, lock_lost8;
    logic [7:0]  err_total8;

    int checks = 0;
    int errors = 0;

    always #5 rx_clk = ~rx_clk;

    eth_phy_10g_prbs31_ctrl dut (
        .rx_clk               (rx_clk),
        .rx_rst               (rx_rst),
        .start                (start),
        .abort                (abort),
        .cfg_test_cycles      (cfg_cycles),
        .cfg_err_threshold    (cfg_thr),
        .rx_block_lock        (lock),
        .rx_error_count       (err),
        .cfg_tx_prbs31_enable (tx_en),
        .cfg_rx_prbs31_enable (rx_en),
        .busy                 (busy),
        .done                 (done),
        .pass                 (pass),
        .timeout              (timeout),
        .lock_lost            (lock_lost),
        .err_total            (err_total)
    );

    eth_phy_10g_prbs31_ctrl #(.ACC_WIDTH(8)) dut8 (
        .rx_clk               (rx_clk),
        .rx_rst               (rx_rst),
        .start                (start),
        .abort                (abort),
        .cfg_test_cycles      (cfg8_cycles),
        .cfg_err_threshold    (cfg8_thr),
        .rx_block_lock        (lock),
        .rx_error_count       (err8),
        .cfg_tx_prbs31_enable (tx_en8),
        .cfg_rx_prbs31_enable (rx_en8),
        .busy                 (busy8),
        .done                 (done8),
        .pass                 (pass8),
        .timeout              (timeout8),
        .lock_lost            (lock_lost8),
        .err_total            (err_total8)
    );

    typedef struct {
        bit          lock_en;     // lock driven high from start
        int          drop_edge;   // edge at which lock goes low (0 = never)
        int          spur_start;  // edge with a start pulse while busy (0 = none)
        logic [6:0]  err;
        logic [31:0] win;
        logic [31:0] thr;
        int          exp_edge;    // edge at which done is expected
        logic [31:0] exp_err;
        bit          exp_pass;
        bit          exp_to;
        bit          exp_ll;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle_clear(input string tag);
        chk({tag, "_busy"},   64'(busy), 64'd0);
        chk({tag, "_tx_en"},  64'(tx_en), 64'd0);
        chk({tag, "_rx_en"},  64'(rx_en), 64'd0);
        chk({tag, "_done"},   64'(done), 64'd0);
        chk({tag, "_pass"},   64'(pass), 64'd0);
        chk({tag, "_to"},     64'(timeout), 64'd0);
        chk({tag, "_ll"},     64'(lock_lost), 64'd0);
        chk({tag, "_err"},    64'(err_total), 64'd0);
    endtask

    // Watch for a stray done or busy over n cycles
    task automatic watch_quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge rx_clk); #1;
            if (done || busy) seen++;
        end
        chk({tag, "_quiet"}, 64'(seen), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    done_edge = -1;
        string tag = $sformatf("vec%0d", idx);
        err        = v.err;
        cfg_cycles = v.win;
        cfg_thr    = v.thr;
        lock       = v.lock_en;
        start      = 1'b1;
        @(posedge rx_clk); #1;
        start = 1'b0;
        chk({tag, "_start_busy"},  64'(busy), 64'd1);
        chk({tag, "_start_tx_en"}, 64'(tx_en), 64'd1);
        chk({tag, "_start_rx_en"}, 64'(rx_en), 64'd1);
        chk({tag, "_start_err"},   64'(err_total), 64'd0);
        for (int c = 1; c <= 3000; c++) begin
            lock  = v.lock_en && (v.drop_edge == 0 || c < v.drop_edge);
            start = (c == v.spur_start);
            @(posedge rx_clk); #1;
            start = 1'b0;
            if (done) begin
                done_edge = c;
                break;
            end
        end
        chk({tag, "_done_edge"}, 64'(done_edge), 64'(v.exp_edge));
        chk({tag, "_err_total"}, 64'(err_total), 64'(v.exp_err));
        chk({tag, "_pass"},      64'(pass), 64'(v.exp_pass));
        chk({tag, "_timeout"},   64'(timeout), 64'(v.exp_to));
        chk({tag, "_lock_lost"}, 64'(lock_lost), 64'(v.exp_ll));
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_en_done"},   64'({tx_en, rx_en}), 64'd0);
        @(posedge rx_clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_err_hold"},   64'(err_total), 64'(v.exp_err));
        $display("vec%0d win=%0d thr=%0d err=%0d -> done_edge=%0d err_total=%0d pass=%0d timeout=%0d lock_lost=%0d",
                 idx, v.win, v.thr, v.err, done_edge, err_total, pass, timeout, lock_lost);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        //            lock drop spur err    win      thr      edge  exp_err  pass to ll
        vecs[0] = '{1'b1, 0,   0,  7'd0,  32'd1000, 32'd0,    1017, 32'd0,   1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 0,   50, 7'd3,  32'd100,  32'd299,  117,  32'd300, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 0,   0,  7'd3,  32'd100,  32'd300,  117,  32'd300, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 0,   0,  7'd3,  32'd100,  32'd1000, 1024, 32'd0,   1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 68,  0,  7'd3,  32'd100,  32'd1000, 68,   32'd153, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 0,   0,  7'd5,  32'd0,    32'd5,    18,   32'd5,   1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 5,   0,  7'd3,  32'd100,  32'd1000, 5,    32'd0,   1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 0,   0,  7'd127, 32'd4,   32'd508,  21,   32'd508, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge rx_clk);
        #1;
        check_idle_clear("reset");
        rx_rst = 1'b0;
        @(posedge rx_clk); #1;
        check_idle_clear("post_reset");

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // 8-bit accumulator: restarted with vec7, lock still held; 10 x 66 saturates
        repeat (20) @(posedge rx_clk);
        #1;
        chk("sat8_err_total", 64'(err_total8), 64'd255);
        chk("sat8_pass",      64'(pass8), 64'd0);
        chk("sat8_busy",      64'(busy8), 64'd0);
        chk("sat8_lock_lost", 64'(lock_lost8), 64'd0);
        $display("sat8 err_total=%0d pass=%0d", err_total8, pass8);

        // Abort while in DONE is ignored: vec7 results hold
        abort = 1'b1;
        @(posedge rx_clk); #1;
        abort = 1'b0;
        chk("abort_done_err",  64'(err_total), 64'd508);
        chk("abort_done_pass", 64'(pass), 64'd1);
        $display("abort_in_done err_total=%0d pass=%0d", err_total, pass);

        // Abort in MEASURE
        cfg_cycles = 32'd100;
        cfg_thr    = 32'd1000;
        err        = 7'd3;
        lock       = 1'b1;
        start      = 1'b1;
        @(posedge rx_clk); #1;
        start = 1'b0;
        repeat (29) @(posedge rx_clk);
        #1;
        chk("abort_meas_err_before", 64'(err_total), 64'd36);
        abort = 1'b1;
        @(posedge rx_clk); #1;
        abort = 1'b0;
        check_idle_clear("abort_meas");
        watch_quiet("abort_meas", 150);
        $display("abort_in_measure busy=%0d err_total=%0d", busy, err_total);

        // Start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge rx_clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_idle_clear("start_abort");
        watch_quiet("start_abort", 30);
        $display("start_abort_idle busy=%0d enables=%0d", busy, tx_en);

        // Asynchronous reset mid-SETTLE
        start = 1'b1;
        @(posedge rx_clk); #1;
        start = 1'b0;
        repeat (5) @(posedge rx_clk);
        #1;
        chk("rst_settle_busy_before", 64'(busy), 64'd1);
        #2;
        rx_rst = 1'b1;
        #1;
        chk("rst_async_tx_en", 64'(tx_en), 64'd0);
        chk("rst_async_rx_en", 64'(rx_en), 64'd0);
        chk("rst_async_busy",  64'(busy), 64'd0);
        @(posedge rx_clk); #1;
        rx_rst = 1'b0;
        check_idle_clear("rst_settle");
        watch_quiet("rst_settle", 30);
        $display("reset_mid_settle busy=%0d enables=%0d", busy, tx_en);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
